// File: rtl/karatsuba_mid_mult_pkg.sv
// Shared constants for the Karatsuba middle-term multiplier: FSM encoding
// and the counter-width helper.
package karatsuba_mid_mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bits needed to count 0..n-1, never less than 1.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/karatsuba_mid_mult_twos_abs.sv
// Magnitude and sign of an (N_BITS+1)-bit two's-complement difference.
module karatsuba_mid_mult_twos_abs #(
    parameter int N_BITS = 4
) (
    input  logic [N_BITS:0]   i_x,
    output logic [N_BITS-1:0] o_mag,
    output logic              o_sign
);

    logic [N_BITS:0] w_negx;

    assign w_negx = ~i_x + 1'b1;
    assign o_sign = i_x[N_BITS];
    // The unreachable code 1000..0 folds to magnitude 0 here.
    assign o_mag  = i_x[N_BITS] ? w_negx[N_BITS-1:0] : i_x[N_BITS-1:0];

endmodule

// File: rtl/karatsuba_mid_mult.sv
// Sign/magnitude of (a1-a0)*(b1-b0) via a fixed-latency shift-add loop,
// valid/ready on both sides.
module karatsuba_mid_mult
    import karatsuba_mid_mult_pkg::*;
#(
    parameter int N_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_BITS:0]       da,
    input  logic [N_BITS:0]       db,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*N_BITS-1:0]   prod,
    output logic                  neg
);

    localparam int CW = clog2(N_BITS);

    logic [1:0]          r_state;
    logic [N_BITS-1:0]   r_ma, r_mb;
    logic [2*N_BITS-1:0] r_acc, r_prod;
    logic [CW-1:0]       r_cnt;
    logic                r_neg_op, r_neg, r_out_valid;

    logic [N_BITS-1:0]   w_ma, w_mb;
    logic                w_sa, w_sb;
    logic [2*N_BITS-1:0] w_addend, w_sum;
    logic                w_last;

    karatsuba_mid_mult_twos_abs #(.N_BITS(N_BITS)) u_abs_a (
        .i_x(da), .o_mag(w_ma), .o_sign(w_sa)
    );
    karatsuba_mid_mult_twos_abs #(.N_BITS(N_BITS)) u_abs_b (
        .i_x(db), .o_mag(w_mb), .o_sign(w_sb)
    );

    assign w_addend = r_mb[r_cnt] ? ({{N_BITS{1'b0}}, r_ma} << r_cnt) : '0;
    assign w_sum    = r_acc + w_addend;
    assign w_last   = (r_cnt == CW'(N_BITS - 1));

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign prod      = r_prod;
    assign neg       = r_neg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ma        <= '0;
            r_mb        <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_neg_op    <= 1'b0;
            r_neg       <= 1'b0;
            r_prod      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_ma     <= w_ma;
                        r_mb     <= w_mb;
                        // A zero factor gives +0, never -0.
                        r_neg_op <= (w_sa ^ w_sb) && (w_ma != '0) && (w_mb != '0);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_prod      <= w_sum;
                        r_neg       <= r_neg_op;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_karatsuba_mid_mult.sv
// Self-checking bench: vector table plus back-pressure, reset and streaming
// sequences, all results checked through a scoreboard queue.
module tb_karatsuba_mid_mult;

    localparam int N = 4;

    typedef struct {
        logic [N:0]     da;
        logic [N:0]     db;
        logic [2*N-1:0] p;
        logic           n;
    } vec_t;

    typedef struct {
        logic [2*N-1:0] p;
        logic           n;
        int             acc;
    } exp_t;

    logic           clk, rst_n, in_valid, in_ready, out_valid, out_ready, neg;
    logic [N:0]     da, db;
    logic [2*N-1:0] prod;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   hs_cyc[$];
    logic seen_rise = 1'b0;
    logic chk_low = 1'b0;

    karatsuba_mid_mult #(.N_BITS(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .da(da), .db(db), .out_valid(out_valid), .out_ready(out_ready),
        .prod(prod), .neg(neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives a pair, waits for acceptance, records the expected result.
    task automatic send(input logic [N:0] a, input logic [N:0] b,
                        input logic [2*N-1:0] p, input logic n);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1; da = a; db = b;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        sb.push_back('{p: p, n: n, acc: cyc + 1});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            seen_rise = 1'b0;
            chk_low   = 1'b0;
        end else begin
            if (chk_low) begin
                chk("valid_one_cycle", int'(out_valid), 0);
                chk_low = 1'b0;
            end
            if (out_valid && !seen_rise) begin
                seen_rise = 1'b1;
                if (sb.size() != 0) chk("latency", cyc - sb[0].acc, N);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("prod", int'(prod), int'(e.p));
                    chk("neg", int'(neg), int'(e.n));
                end
                hs_cyc.push_back(cyc);
                seen_rise = 1'b0;
                chk_low   = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        int   t;
        logic bad;

        vt[0] = '{da: 5'b00011, db: 5'b11110, p: 8'd6,   n: 1'b1};
        vt[1] = '{da: 5'b10001, db: 5'b10001, p: 8'd225, n: 1'b0};
        vt[2] = '{da: 5'b00000, db: 5'b11011, p: 8'd0,   n: 1'b0};
        vt[3] = '{da: 5'b01111, db: 5'b10001, p: 8'd225, n: 1'b1};
        vt[4] = '{da: 5'b11000, db: 5'b11000, p: 8'd64,  n: 1'b0};
        vt[5] = '{da: 5'b10000, db: 5'b00101, p: 8'd0,   n: 1'b0};
        vt[6] = '{da: 5'b00101, db: 5'b01011, p: 8'd55,  n: 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; da = '0; db = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_prod", int'(prod), 0);
        chk("rst_neg", int'(neg), 0);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            send(vt[i].da, vt[i].db, vt[i].p, vt[i].n);
            in_valid = 1'b0;
            drain();
        end

        // Back-pressure: result held, new input ignored while in DONE.
        out_ready = 1'b0;
        send(5'd7, 5'd9, 8'd63, 1'b0);
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("bp_valid_rise", int'(out_valid), 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = (k == 0); da = 5'd1; db = 5'd1;
            chk("bp_hold_prod", int'(prod), 63);
            chk("bp_hold_neg", int'(neg), 0);
            chk("bp_hold_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_ready", int'(in_ready), 1);
        chk("bp_idle_valid", int'(out_valid), 0);
        @(negedge clk);
        chk("bp_pulse_ignored", int'(in_ready), 1);
        chk("bp_sb_empty", sb.size(), 0);

        // Reset two cycles into BUSY discards the operation.
        send(5'd5, 5'd5, 8'd25, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_prod", int'(prod), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) bad = 1'b1;
        end
        chk("no_stale_result", int'(bad), 0);

        // Streaming with in_valid and out_ready held high.
        hs_cyc.delete();
        send(5'b00001, 5'b00001, 8'd1, 1'b0);
        send(5'b01111, 5'b01111, 8'd225, 1'b0);
        send(5'b11000, 5'b00111, 8'd56, 1'b1);
        in_valid = 1'b0;
        drain();
        chk("stream_count", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            chk("stream_gap0", hs_cyc[1] - hs_cyc[0], N + 2);
            chk("stream_gap1", hs_cyc[2] - hs_cyc[1], N + 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
